// File: rtl/paint_ctrl_gen.sv
// paint_ctrl_gen: cursor / palette / brush paint controller for the retro_paint LED matrix.
// Decodes one-cycle button events into cursor moves, palette browsing and square brush
// painting, and emits valid/ready pixel writes to the framebuffer writer.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   init              one-cycle pulse that leaves IDLE
//   btn_valid/code    button event strobe and 8-bit code
//   wr_valid/ready    pixel write handshake; wr_x/wr_y/wr_data held while stalled
//   cursor_x/y        cursor position for the overlay
//   cursor_on         cursor blink phase
//   paleta, pal_idx   palette-browse mode flag and current colour index
//   brush_sz          current brush side in pixels
//   busy              brush write sequence in progress
//   btn_drop          one-cycle pulse when a button event was discarded
module paint_ctrl_gen #(
    parameter int unsigned         COORD_W      = 6,
    parameter int unsigned         PAL_W        = 3,
    parameter int unsigned         BRUSH_MAX    = 4,
    parameter int unsigned         BLINK_W      = 24,
    parameter logic [BLINK_W-1:0]  BLINK_PERIOD = 24'd6000000,
    localparam int unsigned        BSZ_W        = $clog2(BRUSH_MAX + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               init,
    input  logic               btn_valid,
    input  logic [7:0]         btn_code,
    output logic               wr_valid,
    input  logic               wr_ready,
    output logic [COORD_W-1:0] wr_x,
    output logic [COORD_W-1:0] wr_y,
    output logic [PAL_W-1:0]   wr_data,
    output logic [COORD_W-1:0] cursor_x,
    output logic [COORD_W-1:0] cursor_y,
    output logic               cursor_on,
    output logic               paleta,
    output logic [PAL_W-1:0]   pal_idx,
    output logic [BSZ_W-1:0]   brush_sz,
    output logic               busy,
    output logic               btn_drop
);

    localparam int unsigned SW = COORD_W + 1;

    localparam logic [7:0] BtnUp    = 8'h01;
    localparam logic [7:0] BtnDown  = 8'h02;
    localparam logic [7:0] BtnLeft  = 8'h03;
    localparam logic [7:0] BtnRight = 8'h04;
    localparam logic [7:0] BtnEnter = 8'h05;
    localparam logic [7:0] BtnC     = 8'h06;
    localparam logic [7:0] BtnBrush = 8'h07;

    localparam logic [COORD_W-1:0] CMax = '1;

    typedef enum logic [1:0] {StIdle, StReady, StPalette, StPaint} state_e;

    state_e               state_q, state_d;
    logic [COORD_W-1:0]   cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic [COORD_W-1:0]   org_x_q, org_x_d, org_y_q, org_y_d;
    logic [PAL_W-1:0]     pal_q, pal_d;
    logic [BSZ_W-1:0]     brush_q, brush_d;
    logic [BSZ_W-1:0]     i_q, i_d, j_q, j_d;
    logic [BLINK_W-1:0]   blink_q, blink_d;
    logic                 on_q, on_d;
    logic                 drop_q, drop_d;
    logic                 wvalid_q, wvalid_d;
    logic [COORD_W-1:0]   wx_q, wx_d, wy_q, wy_d;
    logic [PAL_W-1:0]     wdata_q, wdata_d;

    logic                 btn_known;
    logic [SW-1:0]        px_sum, py_sum;
    logic                 clipped;
    logic                 last_col, last_pos;
    logic                 advance;
    logic                 moved;

    assign btn_known = (btn_code >= BtnUp) && (btn_code <= BtnBrush);

    // One extra bit catches positions that fall off the right/bottom edge.
    assign px_sum   = {1'b0, org_x_q} + SW'(i_q);
    assign py_sum   = {1'b0, org_y_q} + SW'(j_q);
    assign clipped  = px_sum[COORD_W] | py_sum[COORD_W];
    assign last_col = (i_q == brush_q - 1'b1);
    assign last_pos = last_col && (j_q == brush_q - 1'b1);

    always_comb begin
        state_d  = state_q;
        cur_x_d  = cur_x_q;
        cur_y_d  = cur_y_q;
        org_x_d  = org_x_q;
        org_y_d  = org_y_q;
        pal_d    = pal_q;
        brush_d  = brush_q;
        i_d      = i_q;
        j_d      = j_q;
        blink_d  = blink_q;
        on_d     = on_q;
        drop_d   = 1'b0;
        wvalid_d = wvalid_q;
        wx_d     = wx_q;
        wy_d     = wy_q;
        wdata_d  = wdata_q;
        advance  = 1'b0;
        moved    = 1'b0;

        if (state_q != StIdle) begin
            if (blink_q == BLINK_PERIOD - 1'b1) begin
                blink_d = '0;
                on_d    = ~on_q;
            end else begin
                blink_d = blink_q + 1'b1;
            end
        end

        case (state_q)
            StIdle: begin
                if (btn_valid && btn_known) drop_d = 1'b1;
                if (init) begin
                    state_d = StReady;
                    on_d    = 1'b1;
                    blink_d = '0;
                end
            end

            StReady: begin
                if (btn_valid) begin
                    case (btn_code)
                        BtnUp: begin
                            moved = 1'b1;
                            if (cur_y_q != '0) cur_y_d = cur_y_q - 1'b1;
                        end
                        BtnDown: begin
                            moved = 1'b1;
                            if (cur_y_q != CMax) cur_y_d = cur_y_q + 1'b1;
                        end
                        BtnLeft: begin
                            moved = 1'b1;
                            if (cur_x_q != '0) cur_x_d = cur_x_q - 1'b1;
                        end
                        BtnRight: begin
                            moved = 1'b1;
                            if (cur_x_q != CMax) cur_x_d = cur_x_q + 1'b1;
                        end
                        BtnEnter: begin
                            state_d = StPaint;
                            org_x_d = cur_x_q;
                            org_y_d = cur_y_q;
                            i_d     = '0;
                            j_d     = '0;
                        end
                        BtnC: state_d = StPalette;
                        BtnBrush: begin
                            if (brush_q == BSZ_W'(BRUSH_MAX)) brush_d = BSZ_W'(1);
                            else                               brush_d = brush_q + 1'b1;
                        end
                        default: ;
                    endcase
                end
                // Any move restarts the blink so the cursor is visible right after moving.
                if (moved) begin
                    blink_d = '0;
                    on_d    = 1'b1;
                end
            end

            StPalette: begin
                if (btn_valid) begin
                    case (btn_code)
                        BtnLeft, BtnUp:    pal_d = pal_q - 1'b1;
                        BtnRight, BtnDown: pal_d = pal_q + 1'b1;
                        BtnEnter, BtnC:    state_d = StReady;
                        default: ;
                    endcase
                end
            end

            StPaint: begin
                if (btn_valid && btn_known) drop_d = 1'b1;
                if (wvalid_q) begin
                    if (wr_ready) begin
                        wvalid_d = 1'b0;
                        advance  = 1'b1;
                    end
                end else if (clipped) begin
                    advance = 1'b1;
                end else begin
                    wvalid_d = 1'b1;
                    wx_d     = px_sum[COORD_W-1:0];
                    wy_d     = py_sum[COORD_W-1:0];
                    wdata_d  = pal_q;
                end
                if (advance) begin
                    if (last_pos) begin
                        state_d = StReady;
                    end else if (last_col) begin
                        i_d = '0;
                        j_d = j_q + 1'b1;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cur_x_q  <= '0;
            cur_y_q  <= '0;
            org_x_q  <= '0;
            org_y_q  <= '0;
            pal_q    <= '0;
            brush_q  <= BSZ_W'(1);
            i_q      <= '0;
            j_q      <= '0;
            blink_q  <= '0;
            on_q     <= 1'b0;
            drop_q   <= 1'b0;
            wvalid_q <= 1'b0;
            wx_q     <= '0;
            wy_q     <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cur_x_q  <= cur_x_d;
            cur_y_q  <= cur_y_d;
            org_x_q  <= org_x_d;
            org_y_q  <= org_y_d;
            pal_q    <= pal_d;
            brush_q  <= brush_d;
            i_q      <= i_d;
            j_q      <= j_d;
            blink_q  <= blink_d;
            on_q     <= on_d;
            drop_q   <= drop_d;
            wvalid_q <= wvalid_d;
            wx_q     <= wx_d;
            wy_q     <= wy_d;
            wdata_q  <= wdata_d;
        end
    end

    assign wr_valid  = wvalid_q;
    assign wr_x      = wx_q;
    assign wr_y      = wy_q;
    assign wr_data   = wdata_q;
    assign cursor_x  = cur_x_q;
    assign cursor_y  = cur_y_q;
    assign cursor_on = on_q;
    assign paleta    = (state_q == StPalette);
    assign pal_idx   = pal_q;
    assign brush_sz  = brush_q;
    assign busy      = (state_q == StPaint);
    assign btn_drop  = drop_q;

endmodule

// File: tb/tb_paint_ctrl_gen.sv
// Self-checking bench for paint_ctrl_gen: directed scenarios plus randomized button
// sequences against a behavioural model; expected pixel writes go through a scoreboard
// queue that a separate monitor drains on every accepted handshake.
module tb_paint_ctrl_gen;

    localparam int CW   = 6;
    localparam int PW   = 3;
    localparam int BMAX = 4;
    localparam int MAXC = (1 << CW) - 1;
    localparam int NPAL = 1 << PW;
    localparam int BSZW = $clog2(BMAX + 1);

    logic            clk = 1'b0;
    logic            rst, init, btn_valid, wr_ready;
    logic [7:0]      btn_code;
    logic            wr_valid, cursor_on, paleta, busy, btn_drop;
    logic [CW-1:0]   wr_x, wr_y, cursor_x, cursor_y;
    logic [PW-1:0]   wr_data, pal_idx;
    logic [BSZW-1:0] brush_sz;

    paint_ctrl_gen #(
        .COORD_W      (CW),
        .PAL_W        (PW),
        .BRUSH_MAX    (BMAX),
        .BLINK_W      (24),
        .BLINK_PERIOD (24'd4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .init      (init),
        .btn_valid (btn_valid),
        .btn_code  (btn_code),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_x      (wr_x),
        .wr_y      (wr_y),
        .wr_data   (wr_data),
        .cursor_x  (cursor_x),
        .cursor_y  (cursor_y),
        .cursor_on (cursor_on),
        .paleta    (paleta),
        .pal_idx   (pal_idx),
        .brush_sz  (brush_sz),
        .busy      (busy),
        .btn_drop  (btn_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int d;
    } wr_t;

    wr_t exp_q[$];
    int  n_pass  = 0;
    int  n_total = 0;
    int  ready_mode = 1;  // 0: hold low, 1: hold high, 2: random

    // Behavioural model: 0 idle, 1 ready, 2 palette
    int m_mode, m_x, m_y, m_pal, m_brush;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // wr_ready driver
    initial begin
        wr_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       wr_ready = 1'b0;
                1:       wr_ready = 1'b1;
                default: wr_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Scoreboard monitor: every accepted write must match the queue head
    always @(negedge clk) begin
        if (!rst && wr_valid && wr_ready) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 1, 0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_x", int'(wr_x), e.x);
                check("wr_y", int'(wr_y), e.y);
                check("wr_data", int'(wr_data), e.d);
            end
        end
    end

    task automatic press(input int code);
        @(posedge clk);
        #1;
        btn_valid = 1'b1;
        btn_code  = 8'(code);
        @(posedge clk);
        #1;
        btn_valid = 1'b0;
    endtask

    // Returns 1 when the press starts a paint sequence.
    function automatic bit model_press(input int code);
        bit paint = 1'b0;
        if (m_mode == 1) begin
            case (code)
                1: if (m_y > 0) m_y--;
                2: if (m_y < MAXC) m_y++;
                3: if (m_x > 0) m_x--;
                4: if (m_x < MAXC) m_x++;
                5: begin
                    for (int j = 0; j < m_brush; j++)
                        for (int i = 0; i < m_brush; i++)
                            if (m_x + i <= MAXC && m_y + j <= MAXC)
                                exp_q.push_back('{x: m_x + i, y: m_y + j, d: m_pal});
                    paint = 1'b1;
                end
                6: m_mode = 2;
                7: m_brush = (m_brush == BMAX) ? 1 : m_brush + 1;
                default: ;
            endcase
        end else if (m_mode == 2) begin
            case (code)
                1, 3: m_pal = (m_pal + NPAL - 1) % NPAL;
                2, 4: m_pal = (m_pal + 1) % NPAL;
                5, 6: m_mode = 1;
                default: ;
            endcase
        end
        return paint;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("paint_done", int'(busy), 0);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!wr_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("wr_valid_rise", int'(wr_valid), 1);
    endtask

    task automatic check_state();
        check("cursor_x", int'(cursor_x), m_x);
        check("cursor_y", int'(cursor_y), m_y);
        check("pal_idx", int'(pal_idx), m_pal);
        check("paleta", int'(paleta), (m_mode == 2) ? 1 : 0);
        check("brush_sz", int'(brush_sz), m_brush);
        check("busy", int'(busy), 0);
    endtask

    task automatic do_press(input int code);
        bit p;
        p = model_press(code);
        press(code);
        if (p) begin
            wait_idle();
            check("queue_drained", exp_q.size(), 0);
        end
    endtask

    task automatic press_n(input int code, input int n);
        for (int k = 0; k < n; k++) do_press(code);
    endtask

    initial begin
        int codes[8];
        int c;
        codes = '{1, 2, 3, 4, 5, 6, 7, 8'h42};
        rst = 1'b1;
        init = 1'b0;
        btn_valid = 1'b0;
        btn_code = 8'h00;
        m_mode = 0; m_x = 0; m_y = 0; m_pal = 0; m_brush = 1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_wr_valid", int'(wr_valid), 0);
        check("rst_wr_x", int'(wr_x), 0);
        check("rst_wr_y", int'(wr_y), 0);
        check("rst_wr_data", int'(wr_data), 0);
        check("rst_cursor_on", int'(cursor_on), 0);
        check("rst_btn_drop", int'(btn_drop), 0);
        check_state();

        // Button in IDLE is dropped
        press(1);
        check("idle_drop", int'(btn_drop), 1);
        check("idle_cursor_on", int'(cursor_on), 0);
        @(posedge clk);
        #1;
        check("idle_drop_pulse", int'(btn_drop), 0);

        // init -> READY
        @(posedge clk);
        #1;
        init = 1'b1;
        @(posedge clk);
        #1;
        init = 1'b0;
        m_mode = 1;
        check("init_cursor_on", int'(cursor_on), 1);

        press_n(4, 3);
        press_n(2, 2);
        check_state();
        check("move_cursor_on", int'(cursor_on), 1);
        press_n(1, 5);
        check_state();

        // Palette browse with wrap
        do_press(6);
        check_state();
        press_n(4, 9);
        check_state();
        do_press(5);
        check_state();

        // 3x3 brush at (10,20)
        press_n(4, 7);
        press_n(2, 20);
        press_n(7, 2);
        check_state();
        ready_mode = 1;
        do_press(5);
        check_state();

        // 4x4 brush at (62,63): only two positions survive clipping
        do_press(7);
        press_n(4, 52);
        press_n(2, 43);
        check_state();
        check("clip_count_pre", exp_q.size(), 0);
        do_press(5);
        check_state();

        // Stall mid-sequence, plus a button during PAINT
        press_n(3, 57);
        press_n(1, 58);
        check_state();
        ready_mode = 0;
        void'(model_press(5));
        press(5);
        wait_valid();
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("stall_valid", int'(wr_valid), 1);
            if (exp_q.size() > 0) begin
                check("stall_x", int'(wr_x), exp_q[0].x);
                check("stall_y", int'(wr_y), exp_q[0].y);
                check("stall_d", int'(wr_data), exp_q[0].d);
            end else begin
                check("stall_queue", 0, 1);
            end
        end
        press(2);
        check("paint_drop", int'(btn_drop), 1);
        ready_mode = 2;
        wait_idle();
        check("queue_drained", exp_q.size(), 0);
        check_state();

        // Blink: LEFT restarts the count, then cursor_on toggles every 4 cycles
        do_press(3);
        check("blink_start", int'(cursor_on), 1);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            check("blink", int'(cursor_on), ((k / 4) % 2 == 0) ? 1 : 0);
        end

        // Randomized button sequences
        for (int n = 0; n < 150; n++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            c = codes[$urandom_range(0, 7)];
            do_press(c);
            check("no_drop", int'(btn_drop), 0);
            check_state();
        end

        // Reset in the middle of a write
        if (m_mode == 2) do_press(6);
        ready_mode = 0;
        void'(model_press(5));
        press(5);
        wait_valid();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        m_mode = 0; m_x = 0; m_y = 0; m_pal = 0; m_brush = 1;
        check("rstmid_wr_valid", int'(wr_valid), 0);
        check("rstmid_cursor_on", int'(cursor_on), 0);
        check_state();
        press(4);
        check("rstmid_idle_drop", int'(btn_drop), 1);
        check_state();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
